// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART TX arbiter.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2
    } arb_state_e;

    localparam logic [3:0] HDR_MAGIC = 4'hA;

    // Width of a requester index; never below one bit.
    function automatic int id_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin selector: first asserted request after last_grant_i, with wrap.
// Zero latency; pure function of its inputs.
module rr_pick
    import uart_arb_pkg::*;
#(
    parameter int  NUM_REQ = 4,
    localparam int ID_W    = id_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    last_grant_i,
    output logic               any_req_o,
    output logic [ID_W-1:0]    pick_id_o
);

    logic [ID_W-1:0] cand;

    always_comb begin
        any_req_o = 1'b0;
        pick_id_o = '0;
        cand      = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand = ID_W'((int'(last_grant_i) + off) % NUM_REQ);
            if (!any_req_o && req_i[cand]) begin
                any_req_o = 1'b1;
                pick_id_o = cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, frame-atomic sharing of one TX FIFO write port; 1-cycle arbitration, optional ID header.
// Writes and req_ready are combinational and gated by tx_fifo_full, so a full FIFO stalls without loss.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int  NUM_REQ      = 4,
    parameter int  ADD_HDR      = 1,
    parameter int  IDLE_TIMEOUT = 64,
    localparam int ID_W         = id_w(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic                 tx_fifo_full,
    output logic [7:0]           tx_data,
    output logic                 tx_wr_en,
    output logic [ID_W-1:0]      grant_id,
    output logic                 busy,
    output logic                 abort
);

    localparam int CNT_W = (IDLE_TIMEOUT < 2) ? 1 : $clog2(IDLE_TIMEOUT);

    arb_state_e      state_q, state_d;
    logic [ID_W-1:0] grant_q, grant_d;
    logic [ID_W-1:0] last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic            any_req;
    logic [ID_W-1:0] pick_id;
    logic            valid_g;
    logic            last_g;
    logic [7:0]      data_g;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req_i        (req_valid),
        .last_grant_i (last_q),
        .any_req_o    (any_req),
        .pick_id_o    (pick_id)
    );

    assign valid_g  = req_valid[grant_q];
    assign last_g   = req_last[grant_q];
    assign data_g   = req_data[{grant_q, 3'b000} +: 8];
    assign grant_id = grant_q;
    assign busy     = (state_q != IDLE);

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        req_ready = '0;
        tx_wr_en  = 1'b0;
        tx_data   = '0;
        abort     = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    grant_d = pick_id;
                    cnt_d   = '0;
                    state_d = (ADD_HDR != 0) ? HDR : DATA;
                end
            end
            HDR: begin
                tx_wr_en = !tx_fifo_full;
                tx_data  = {HDR_MAGIC, 4'(grant_q)};
                if (!tx_fifo_full) begin
                    state_d = DATA;
                    cnt_d   = '0;
                end
            end
            DATA: begin
                req_ready[grant_q] = !tx_fifo_full;
                if (valid_g && !tx_fifo_full) begin
                    tx_wr_en = 1'b1;
                    tx_data  = data_g;
                    cnt_d    = '0;
                    if (last_g) begin
                        state_d = IDLE;
                        last_d  = grant_q;
                    end
                end else if (!valid_g && !tx_fifo_full && IDLE_TIMEOUT != 0) begin
                    // The cycle that would bring the count to IDLE_TIMEOUT is the release cycle.
                    if (cnt_q == CNT_W'(IDLE_TIMEOUT - 1)) begin
                        abort   = 1'b1;
                        state_d = IDLE;
                        last_d  = grant_q;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= ID_W'(NUM_REQ - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench: frame-level reference model compared every cycle, plus directed literal scenarios.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int TO = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic           tx_fifo_full;
    logic [7:0]     tx_data;
    logic           tx_wr_en;
    logic [1:0]     grant_id;
    logic           busy;
    logic           abort;

    uart_tx_arbiter #(.NUM_REQ(N), .ADD_HDR(1), .IDLE_TIMEOUT(TO)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .tx_fifo_full (tx_fifo_full),
        .tx_data      (tx_data),
        .tx_wr_en     (tx_wr_en),
        .grant_id     (grant_id),
        .busy         (busy),
        .abort        (abort)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    logic [8:0] txq [N][$];     // per-requester pending bytes {last, data}
    bit         hs [N];
    int         gap_pct   = 0;
    int         full_pct  = 0;
    bit         force_full = 1'b0;

    logic [7:0] wr_log[$];
    int         wr_cyc[$];
    int         ab_cyc[$];

    // Reference: who owns the port (-1 none), whether its header is still owed, idle-run length.
    int m_owner = -1;
    int m_last  = N - 1;
    int m_gid   = 0;
    int m_quiet = 0;
    bit m_hdr   = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chk_log(input string nm, input logic [7:0] e[$]);
        chk({nm, "_len"}, wr_log.size(), e.size());
        for (int i = 0; i < e.size(); i++)
            chk(nm, (i < wr_log.size()) ? 32'(wr_log[i]) : 32'hDEAD, 32'(e[i]));
    endtask

    function automatic int pending();
        int s;
        s = busy ? 1 : 0;
        for (int i = 0; i < N; i++) s += txq[i].size();
        return s;
    endfunction

    task automatic clear_logs();
        wr_log.delete();
        wr_cyc.delete();
        ab_cyc.delete();
    endtask

    always @(negedge clk) begin : cmp
        logic [N-1:0] e_rdy;
        logic         e_wr, e_ab, e_busy;
        logic [7:0]   e_dat;
        int           e_gid, c;
        e_rdy  = '0;
        e_wr   = 1'b0;
        e_ab   = 1'b0;
        e_dat  = '0;
        e_busy = (m_owner >= 0);
        e_gid  = m_gid;
        for (int i = 0; i < N; i++) hs[i] = req_valid[i] && req_ready[i];
        if (rst) begin
            m_owner = -1; m_last = N - 1; m_gid = 0; m_quiet = 0; m_hdr = 1'b0;
            e_busy  = 1'b0; e_gid = 0;
            chk("rst_tx_data", tx_data, 0);
        end else if (m_owner < 0) begin
            for (int k = 1; k <= N; k++) begin
                c = (m_last + k) % N;
                if (m_owner < 0 && req_valid[c]) begin
                    m_owner = c; m_gid = c; m_hdr = 1'b1; m_quiet = 0;
                end
            end
        end else if (m_hdr) begin
            e_wr  = !tx_fifo_full;
            e_dat = 8'hA0 | 8'(m_owner);
            if (!tx_fifo_full) m_hdr = 1'b0;
        end else begin
            e_rdy[m_owner] = !tx_fifo_full;
            if (!tx_fifo_full && req_valid[m_owner]) begin
                e_wr    = 1'b1;
                e_dat   = req_data[8*m_owner +: 8];
                m_quiet = 0;
                if (req_last[m_owner]) begin
                    m_last = m_owner; m_owner = -1;
                end
            end else if (!tx_fifo_full) begin
                m_quiet++;
                if (m_quiet == TO) begin
                    e_ab = 1'b1; m_last = m_owner; m_owner = -1; m_quiet = 0;
                end
            end
        end
        chk("tx_wr_en", tx_wr_en, e_wr);
        if (e_wr) chk("tx_data", tx_data, e_dat);
        chk("req_ready", req_ready, e_rdy);
        chk("busy", busy, e_busy);
        chk("grant_id", grant_id, e_gid);
        chk("abort", abort, e_ab);
        if (tx_wr_en) begin
            wr_log.push_back(tx_data);
            wr_cyc.push_back(cyc);
        end
        if (abort) ab_cyc.push_back(cyc);
    end

    initial begin : drv
        req_valid    = '0;
        req_last     = '0;
        req_data     = '0;
        tx_fifo_full = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (hs[i] && txq[i].size() > 0) void'(txq[i].pop_front());
                if (txq[i].size() > 0 && $urandom_range(99) >= gap_pct) begin
                    req_valid[i]         = 1'b1;
                    req_data[8*i +: 8]   = txq[i][0][7:0];
                    req_last[i]          = txq[i][0][8];
                end else begin
                    req_valid[i]         = 1'b0;
                    req_last[i]          = 1'(($urandom_range(1)));
                    req_data[8*i +: 8]   = 8'($urandom);
                end
            end
            tx_fifo_full = force_full || ($urandom_range(99) < full_pct);
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst = 1'b1;
        for (int i = 0; i < N; i++) txq[i].delete();
        #1;
        chk("arst_wr_en", tx_wr_en, 0);
        chk("arst_ready", req_ready, 0);
        chk("arst_busy", busy, 0);
        chk("arst_grant", grant_id, 0);
        chk("arst_abort", abort, 0);
        chk("arst_data", tx_data, 0);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [7:0] e[$];
        int         c0, len, r, w;
        logic       lst;
        rst = 1'b0;
        #1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        chk("reset_busy", busy, 0);
        chk("reset_grant", grant_id, 0);
        chk("reset_wr_en", tx_wr_en, 0);
        rst = 1'b0;

        // Single frame from req1 with header.
        @(posedge clk); #2;
        clear_logs();
        txq[1].push_back({1'b0, 8'h41});
        txq[1].push_back({1'b1, 8'h42});
        @(posedge clk); #2;
        c0 = cyc;
        repeat (6) @(posedge clk);
        #2;
        e = '{8'hA1, 8'h41, 8'h42};
        chk_log("single", e);
        chk("single_hdr_lat", (wr_cyc.size() == 3) ? wr_cyc[0] - c0 : -1, 1);
        chk("single_end_lat", (wr_cyc.size() == 3) ? wr_cyc[2] - c0 : -1, 3);
        chk("single_busy_after", busy, 0);

        // Contention from reset: priority starts at req0.
        do_reset();
        clear_logs();
        txq[0].push_back({1'b1, 8'h10});
        txq[2].push_back({1'b1, 8'h30});
        txq[3].push_back({1'b1, 8'h40});
        repeat (15) @(posedge clk);
        #2;
        e = '{8'hA0, 8'h10, 8'hA2, 8'h30, 8'hA3, 8'h40};
        chk_log("contend", e);

        // Round two: req0 arrives late and must wait behind req2 and req3.
        clear_logs();
        txq[2].push_back({1'b1, 8'h30});
        txq[3].push_back({1'b1, 8'h40});
        @(posedge clk); #2;
        txq[0].push_back({1'b1, 8'h10});
        repeat (15) @(posedge clk);
        #2;
        e = '{8'hA2, 8'h30, 8'hA3, 8'h40, 8'hA0, 8'h10};
        chk_log("contend2", e);

        // Idle timeout: req2 stops without last; req3 waits and is served next.
        do_reset();
        clear_logs();
        txq[2].push_back({1'b0, 8'h55});
        @(posedge clk); #2;
        txq[3].push_back({1'b1, 8'h66});
        repeat (25) @(posedge clk);
        #2;
        e = '{8'hA2, 8'h55, 8'hA3, 8'h66};
        chk_log("timeout", e);
        chk("timeout_pulses", ab_cyc.size(), 1);
        chk("timeout_delay", (ab_cyc.size() == 1 && wr_cyc.size() >= 2) ? ab_cyc[0] - wr_cyc[1] : -1, TO);

        // Backpressure mid-frame plus atomicity against a waiting req1.
        do_reset();
        clear_logs();
        txq[0].push_back({1'b0, 8'h81});
        txq[0].push_back({1'b0, 8'h82});
        txq[0].push_back({1'b0, 8'h83});
        txq[0].push_back({1'b1, 8'h84});
        txq[1].push_back({1'b1, 8'h99});
        @(posedge clk); #2;
        @(posedge clk); #2;
        @(posedge clk); #2;
        force_full = 1'b1;
        repeat (10) @(posedge clk);
        #2;
        force_full = 1'b0;
        repeat (15) @(posedge clk);
        #2;
        e = '{8'hA0, 8'h81, 8'h82, 8'h83, 8'h84, 8'hA1, 8'h99};
        chk_log("backpressure", e);
        chk("bp_no_abort", ab_cyc.size(), 0);

        // Asynchronous reset in the middle of a req3 frame.
        do_reset();
        clear_logs();
        txq[3].push_back({1'b0, 8'h71});
        txq[3].push_back({1'b0, 8'h72});
        txq[3].push_back({1'b1, 8'h73});
        @(posedge clk); #2;
        repeat (2) @(posedge clk);
        #2;
        chk("pre_rst_busy", busy, 1);
        do_reset();
        clear_logs();
        txq[3].push_back({1'b1, 8'h77});
        txq[0].push_back({1'b1, 8'h11});
        repeat (12) @(posedge clk);
        #2;
        e = '{8'hA0, 8'h11, 8'hA3, 8'h77};
        chk_log("post_rst", e);
        chk("post_rst_no_abort", ab_cyc.size(), 0);

        // Randomized traffic with gaps and FIFO-full noise; the model checks every cycle.
        gap_pct  = 20;
        full_pct = 25;
        for (int f = 0; f < 150; f++) begin
            r   = $urandom_range(N - 1);
            len = $urandom_range(4, 1);
            for (int b = 0; b < len; b++) begin
                lst = (b == len - 1);
                txq[r].push_back({lst, 8'($urandom)});
            end
            if ($urandom_range(3) == 0) @(posedge clk);
        end
        w = 0;
        while (pending() != 0 && w < 20000) begin
            @(posedge clk);
            w++;
        end
        #2;
        chk("random_drain", pending(), 0);
        gap_pct  = 0;
        full_pct = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares the single TX FIFO write port of uart_with_fifo_top between NUM_REQ byte-stream requesters. Each requester sends a frame using valid/ready/last. The arbiter grants round-robin and holds the grant for the whole frame. It optionally prepends a header byte that carries the requester ID, and it drives tx_data/tx_wr_en directly from tx_fifo_full. The block sits between the client logic and uart_with_fifo_top.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
ADD_HDR, 1, 1 = prepend header byte {4'hA, id[3:0]} to each frame
IDLE_TIMEOUT, 64, cycles of granted-but-no-valid in DATA before forced release; 0 disables

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
req_valid  in  NUM_REQ  per-requester byte valid
req_data  in  8*NUM_REQ  per-requester byte; requester i on bits [8i+7:8i]
req_last  in  NUM_REQ  marks final byte of frame
req_ready  out  NUM_REQ  per-requester accept
tx_fifo_full  in  1  from uart_with_fifo_top
tx_data  out  8  to TX FIFO
tx_wr_en  out  1  TX FIFO write strobe, one byte per cycle
grant_id  out  ID_W  current/last granted requester, ID_W = max(1, clog2(NUM_REQ))
busy  out  1  high in HDR or DATA
abort  out  1  one-cycle pulse on timeout release

Behaviour:
- Reset (async): state=IDLE, grant_id=0, last_grant=NUM_REQ-1 (so req 0 has first priority), timeout count=0. All outputs 0.
- Reset mid-frame aborts immediately. The partial frame already in the FIFO is not recalled, and no abort pulse is issued.
- IDLE:
  - If any req_valid is high, pick the first valid index searching from last_grant+1 with wrap, and register it into grant_id.
  - Next state: HDR if ADD_HDR, else DATA.
  - req_ready=0 and no write in this state; arbitration costs exactly one cycle.
- HDR:
  - tx_wr_en = !tx_fifo_full; tx_data = {4'hA, grant_id}.
  - Advance to DATA on the write; stall in HDR while the FIFO is full.
- DATA:
  - req_ready[grant_id] = !tx_fifo_full; all other ready bits are 0.
  - Transfer condition is req_valid[g] && req_ready[g]. On transfer, tx_wr_en=1 and tx_data = req_data[g].
  - A transfer with req_last set returns to IDLE and sets last_grant=grant_id.
- Outputs tx_wr_en, tx_data and req_ready are combinational from state, grant_id, req_valid and tx_fifo_full, so a write never occurs while full.
- Timeout:
  - The counter increments in DATA on cycles where req_valid[g]=0.
  - It clears on any transfer and on entry to DATA.
  - A cycle stalled by tx_fifo_full does not count.
  - When count reaches IDLE_TIMEOUT: pulse abort, go to IDLE, set last_grant=grant_id.
- Non-granted requesters may hold valid indefinitely and are never written.
- grant_id holds its value in IDLE until the next grant.
- Latency: valid asserted in IDLE at cycle t gives the header write at t+1 and the first data write at t+2 (FIFO not full). Without header, the first data write is at t+1.
- Back-to-back frames: minimum one IDLE cycle between frames.

Decomposition:
- Package uart_arb_pkg:
  - state enum IDLE/HDR/DATA
  - HDR_MAGIC = 4'hA
  - ID_W helper function
- Sub-module rr_pick: combinational round-robin selector. Inputs are the request vector and last_grant; outputs are any_req and pick_id.

Test Plan:
- Single frame, ADD_HDR=1: req1 sends 0x41,0x42(last) with FIFO never full -> FIFO writes 0xA1,0x41,0x42 on consecutive cycles starting one cycle after valid; busy falls after 0x42; loopback RX FIFO yields A1 41 42.
- Contention: req0,req2,req3 all valid with single-byte frames 0x10/0x30/0x40 from reset -> order 0xA0,0x10,0xA2,0x30,0xA3,0x40. Repeat with req0 reasserted -> order 2,3,0.
- Frame atomicity: req0 sends a 3-byte frame while req1 is valid throughout -> no req1 byte is interleaved; req_ready[1] stays 0 until req0's last byte.
- Backpressure: tx_fifo_full forced high for 10 cycles mid-frame -> tx_wr_en=0 and req_ready=0 for those 10 cycles; no byte lost or duplicated; timeout does not fire.
- Timeout, IDLE_TIMEOUT=8: req2 sends one byte without last, then drops valid -> abort pulses exactly 8 cycles later; state returns to IDLE; req3 is granted next.
- Async reset asserted mid-frame between clock edges -> all outputs 0 immediately; after release, req0 has priority over req3.
